// File: rtl/zdos_trigger.sv
// DOS/TR-DOS trigger: synchronizes Z80 bus strobes into fclk and emits one-cycle
// DOS on/off, VG93 access and NMI-clear pulses. Optional ZDOS_TRIG_GLITCH_FILTER_EN.
module zdos_trigger #(
    parameter logic [7:0] DOS_ENTRY_HI = 8'h3D,
    parameter logic [7:0] NMI_CLR_PORT = 8'hBE,
    parameter int         SYNC_STAGES  = 2      // legal range 2..4
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        z_m1_n,
    input  logic        z_mreq_n,
    input  logic        z_iorq_n,
    input  logic        z_rd_n,
    input  logic        z_wr_n,
    input  logic [15:0] z_a,
    input  logic        dos,
    input  logic        rom48,
    input  logic        romnram,
    output logic        dos_turn_on,
    output logic        dos_turn_off,
    output logic        vg_rdwr_fclk,
    output logic [1:0]  vg_a,
    output logic        clr_nmi
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_IO   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [4:0]             strb_sync_q [SYNC_STAGES];
    logic [15:0]            addr_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] settle_q;
    logic [1:0]             state_q, state_d;
    logic                   armed_q, armed_d;
    logic                   turn_on_q, turn_off_q, vg_hit_q, clr_nmi_q;
    logic [1:0]             vg_a_q;

    logic        m1_s, mreq_s, iorq_s, rd_s, wr_s;
    logic [15:0] a_s;
    logic        s_mem, s_io, clash, mem_go, io_go, ready;

    // NOTE: the synchronizer arrays are reset on purpose: strobes must read inactive
    // and the address neutral from the first cycle, so they are not treated as RAM.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strb_sync_q[i] <= '1;
                addr_sync_q[i] <= '0;
            end
            settle_q <= '0;
        end else begin
            strb_sync_q[0] <= {z_m1_n, z_mreq_n, z_iorq_n, z_rd_n, z_wr_n};
            addr_sync_q[0] <= z_a;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strb_sync_q[i] <= strb_sync_q[i-1];
                addr_sync_q[i] <= addr_sync_q[i-1];
            end
            settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign {m1_s, mreq_s, iorq_s, rd_s, wr_s} = strb_sync_q[SYNC_STAGES-1];
    assign a_s    = addr_sync_q[SYNC_STAGES-1];
    assign s_mem  = ~mreq_s & (~rd_s | ~wr_s);
    assign s_io   = ~iorq_s & (~rd_s | ~wr_s);
    assign clash  = ~iorq_s & (~m1_s | ~mreq_s);
    // HOLD may only release once the chain carries real bus levels, so a strobe
    // held low across reset is not mistaken for an idle bus.
    assign ready  = settle_q[SYNC_STAGES-1];

`ifdef ZDOS_TRIG_GLITCH_FILTER_EN
    logic s_mem_q, s_io_q;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            s_mem_q <= 1'b0;
            s_io_q  <= 1'b0;
        end else begin
            s_mem_q <= s_mem;
            s_io_q  <= s_io;
        end
    end

    assign mem_go = s_mem & s_mem_q;
    assign io_go  = s_io & s_io_q & m1_s;
`else
    assign mem_go = s_mem;
    assign io_go  = s_io & m1_s;
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        case (state_q)
            ST_IDLE: begin
                if (armed_q) begin
                    if (clash) begin
                        state_d = ST_HOLD;
                        armed_d = 1'b0;
                    end else if (mem_go) begin
                        state_d = ST_MEM;
                        armed_d = 1'b0;
                    end else if (io_go) begin
                        state_d = ST_IO;
                        armed_d = 1'b0;
                    end
                end
            end
            ST_MEM, ST_IO: state_d = ST_HOLD;
            default: begin
                if (ready && mreq_s && iorq_s) begin
                    state_d = ST_IDLE;
                    armed_d = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            armed_q    <= 1'b0;
            turn_on_q  <= 1'b0;
            turn_off_q <= 1'b0;
            vg_hit_q   <= 1'b0;
            clr_nmi_q  <= 1'b0;
            vg_a_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            turn_on_q  <= (state_q == ST_MEM) & ~m1_s & (a_s[15:8] == DOS_ENTRY_HI)
                          & romnram & rom48 & ~dos;
            turn_off_q <= (state_q == ST_MEM) & ~m1_s & (a_s[15:14] != 2'b00) & dos;
            vg_hit_q   <= (state_q == ST_IO) & ~a_s[7] & (a_s[1:0] == 2'b11) & dos;
            clr_nmi_q  <= (state_q == ST_IO) & (a_s[7:0] == NMI_CLR_PORT) & ~wr_s;
            if ((state_q == ST_IO) && !a_s[7] && (a_s[1:0] == 2'b11) && dos)
                vg_a_q <= a_s[6:5];
        end
    end

    assign dos_turn_on  = turn_on_q;
    assign dos_turn_off = turn_off_q;
    assign vg_rdwr_fclk = vg_hit_q;
    assign vg_a         = vg_a_q;
    assign clr_nmi      = clr_nmi_q;

endmodule

// File: tb/tb_zdos_trigger.sv
// Directed self-checking bench for zdos_trigger; honours ZDOS_TRIG_GLITCH_FILTER_EN
// when the same macro is defined for the build.
module tb_zdos_trigger;

    localparam int SYNC = 2;
    // Strobe driven just after a negedge is captured on edge 1; the pulse follows
    // edge 1+SYNC+1 and is seen on the negedge after it (plus one with the filter).
`ifdef ZDOS_TRIG_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 3;
`else
    localparam int LAT = SYNC + 2;
`endif

    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        z_m1_n = 1'b1, z_mreq_n = 1'b1, z_iorq_n = 1'b1, z_rd_n = 1'b1, z_wr_n = 1'b1;
    logic [15:0] z_a = 16'h0000;
    logic        dos = 1'b0, rom48 = 1'b0, romnram = 1'b0;
    logic        dos_turn_on, dos_turn_off, vg_rdwr_fclk, clr_nmi;
    logic [1:0]  vg_a;

    int errors = 0;
    int checks = 0;
    int n_on, n_off, n_vg, n_nmi, first_on, first_off, first_vg, first_nmi;

    always #5 fclk = ~fclk;

    zdos_trigger #(
        .DOS_ENTRY_HI(8'h3D),
        .NMI_CLR_PORT(8'hBE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .fclk        (fclk),
        .rst         (rst),
        .z_m1_n      (z_m1_n),
        .z_mreq_n    (z_mreq_n),
        .z_iorq_n    (z_iorq_n),
        .z_rd_n      (z_rd_n),
        .z_wr_n      (z_wr_n),
        .z_a         (z_a),
        .dos         (dos),
        .rom48       (rom48),
        .romnram     (romnram),
        .dos_turn_on (dos_turn_on),
        .dos_turn_off(dos_turn_off),
        .vg_rdwr_fclk(vg_rdwr_fclk),
        .vg_a        (vg_a),
        .clr_nmi     (clr_nmi)
    );

    task automatic clear_mon();
        n_on = 0; n_off = 0; n_vg = 0; n_nmi = 0;
        first_on = -1; first_off = -1; first_vg = -1; first_nmi = -1;
    endtask

    task automatic sample_outputs(input int idx);
        @(negedge fclk);
        if (dos_turn_on)  begin n_on++;  if (first_on  < 0) first_on  = idx; end
        if (dos_turn_off) begin n_off++; if (first_off < 0) first_off = idx; end
        if (vg_rdwr_fclk) begin n_vg++;  if (first_vg  < 0) first_vg  = idx; end
        if (clr_nmi)      begin n_nmi++; if (first_nmi < 0) first_nmi = idx; end
    endtask

    // One bus cycle: strobes low for 'low' fclk, then released for 'tail' fclk.
    task automatic bus(input logic m1, input logic mreq, input logic iorq, input logic rd,
                       input logic wr, input logic [15:0] addr, input int low, input int tail);
        clear_mon();
        z_a = addr;
        z_m1_n = m1; z_mreq_n = mreq; z_iorq_n = iorq; z_rd_n = rd; z_wr_n = wr;
        for (int i = 1; i <= low; i++) sample_outputs(i);
        z_m1_n = 1'b1; z_mreq_n = 1'b1; z_iorq_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
        for (int i = low + 1; i <= low + tail; i++) sample_outputs(i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge fclk);
        checks++; if (dos_turn_on !== 1'b0)  begin errors++; $display("FAIL reset_on: got %b want 0", dos_turn_on); end
        checks++; if (dos_turn_off !== 1'b0) begin errors++; $display("FAIL reset_off: got %b want 0", dos_turn_off); end
        checks++; if (vg_rdwr_fclk !== 1'b0) begin errors++; $display("FAIL reset_vg: got %b want 0", vg_rdwr_fclk); end
        checks++; if (vg_a !== 2'b00)        begin errors++; $display("FAIL reset_vg_a: got %b want 00", vg_a); end
        checks++; if (clr_nmi !== 1'b0)      begin errors++; $display("FAIL reset_nmi: got %b want 0", clr_nmi); end
        rst = 1'b0;
        repeat (4) @(negedge fclk);
    endtask

    task automatic test_dos_on();
        dos = 1'b0; rom48 = 1'b1; romnram = 1'b1;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3D2F, 6, 6);
        checks++; if (n_on !== 1)       begin errors++; $display("FAIL on_count: got %0d want 1", n_on); end
        checks++; if (first_on !== LAT) begin errors++; $display("FAIL on_latency: got %0d want %0d", first_on, LAT); end
        checks++; if (n_off !== 0)      begin errors++; $display("FAIL on_no_off: got %0d want 0", n_off); end
    endtask

    task automatic test_dos_off();
        dos = 1'b1;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 6, 6);
        checks++; if (n_off !== 1)       begin errors++; $display("FAIL off_count: got %0d want 1", n_off); end
        checks++; if (first_off !== LAT) begin errors++; $display("FAIL off_latency: got %0d want %0d", first_off, LAT); end
        checks++; if (n_on !== 0)        begin errors++; $display("FAIL off_no_on: got %0d want 0", n_on); end
        dos = 1'b0;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 6, 6);
        checks++; if (n_off !== 0) begin errors++; $display("FAIL off_dos0: got %0d want 0", n_off); end
        dos = 1'b1;
        bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 6, 6);
        checks++; if (n_off !== 0) begin errors++; $display("FAIL off_non_m1: got %0d want 0", n_off); end
    endtask

    task automatic test_vg();
        dos = 1'b1;
        bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1F7F, 6, 6);
        checks++; if (n_vg !== 1)     begin errors++; $display("FAIL vg_in7f: got %0d want 1", n_vg); end
        checks++; if (vg_a !== 2'b11) begin errors++; $display("FAIL vg_a_7f: got %b want 11", vg_a); end
        bus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h003F, 6, 6);
        checks++; if (n_vg !== 1)     begin errors++; $display("FAIL vg_out3f: got %0d want 1", n_vg); end
        checks++; if (vg_a !== 2'b01) begin errors++; $display("FAIL vg_a_3f: got %b want 01", vg_a); end
        bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF, 6, 6);
        checks++; if (n_vg !== 0)     begin errors++; $display("FAIL vg_ff: got %0d want 0", n_vg); end
        checks++; if (vg_a !== 2'b01) begin errors++; $display("FAIL vg_a_ff: got %b want 01", vg_a); end
        dos = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1F7F, 6, 6);
        checks++; if (n_vg !== 0)     begin errors++; $display("FAIL vg_dos0: got %0d want 0", n_vg); end
        checks++; if (vg_a !== 2'b01) begin errors++; $display("FAIL vg_a_dos0: got %b want 01", vg_a); end
    endtask

    task automatic test_nmi();
        dos = 1'b0;
        bus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00BE, 6, 6);
        checks++; if (n_nmi !== 1) begin errors++; $display("FAIL nmi_out: got %0d want 1", n_nmi); end
        bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00BE, 6, 6);
        checks++; if (n_nmi !== 0) begin errors++; $display("FAIL nmi_in: got %0d want 0", n_nmi); end
        dos = 1'b1;
        bus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h12BE, 20, 6);
        checks++; if (n_nmi !== 1) begin errors++; $display("FAIL nmi_long: got %0d want 1", n_nmi); end
    endtask

    task automatic test_rst_mid();
        dos = 1'b0; rom48 = 1'b1; romnram = 1'b1;
        z_a = 16'h3D00; z_m1_n = 1'b0; z_mreq_n = 1'b0; z_rd_n = 1'b0;
        repeat (LAT) @(negedge fclk);
        checks++; if (dos_turn_on !== 1'b1) begin errors++; $display("FAIL mid_pre_pulse: got %b want 1", dos_turn_on); end
        rst = 1'b1;
        #1;
        checks++; if (dos_turn_on !== 1'b0)  begin errors++; $display("FAIL mid_rst_on: got %b want 0", dos_turn_on); end
        checks++; if (dos_turn_off !== 1'b0) begin errors++; $display("FAIL mid_rst_off: got %b want 0", dos_turn_off); end
        checks++; if (vg_rdwr_fclk !== 1'b0) begin errors++; $display("FAIL mid_rst_vg: got %b want 0", vg_rdwr_fclk); end
        checks++; if (vg_a !== 2'b00)        begin errors++; $display("FAIL mid_rst_vg_a: got %b want 00", vg_a); end
        checks++; if (clr_nmi !== 1'b0)      begin errors++; $display("FAIL mid_rst_nmi: got %b want 0", clr_nmi); end
        repeat (2) @(negedge fclk);
        rst = 1'b0;
        clear_mon();
        for (int i = 1; i <= 10; i++) sample_outputs(i);
        checks++; if (n_on !== 0) begin errors++; $display("FAIL mid_held_strobe: got %0d want 0", n_on); end
        z_m1_n = 1'b1; z_mreq_n = 1'b1; z_rd_n = 1'b1;
        repeat (5) @(negedge fclk);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3D00, 6, 6);
        checks++; if (n_on !== 1) begin errors++; $display("FAIL mid_next_fetch: got %0d want 1", n_on); end
    endtask

    task automatic test_inta();
        dos = 1'b0; rom48 = 1'b1; romnram = 1'b1;
        bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3D00, 6, 6);
        checks++; if (n_on + n_off + n_vg + n_nmi !== 0) begin errors++; $display("FAIL inta: got %0d pulses want 0", n_on + n_off + n_vg + n_nmi); end
        dos = 1'b1;
        bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3D7F, 6, 6);
        checks++; if (n_on + n_off + n_vg + n_nmi !== 0) begin errors++; $display("FAIL mreq_iorq: got %0d pulses want 0", n_on + n_off + n_vg + n_nmi); end
    endtask

    task automatic test_glitch();
        dos = 1'b0; rom48 = 1'b1; romnram = 1'b1;
`ifdef ZDOS_TRIG_GLITCH_FILTER_EN
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3D00, 1, 6);
        checks++; if (n_on !== 0) begin errors++; $display("FAIL glitch_filtered: got %0d want 0", n_on); end
`else
        dos = 1'b1;
        bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h007F, 1, 6);
        checks++; if (n_vg !== 1)   begin errors++; $display("FAIL short_io: got %0d want 1", n_vg); end
        checks++; if (first_vg !== LAT) begin errors++; $display("FAIL short_io_lat: got %0d want %0d", first_vg, LAT); end
        dos = 1'b0;
`endif
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3D00, 3, 6);
        checks++; if (n_on !== 1)       begin errors++; $display("FAIL strobe3_count: got %0d want 1", n_on); end
        checks++; if (first_on !== LAT) begin errors++; $display("FAIL strobe3_latency: got %0d want %0d", first_on, LAT); end
    endtask

    task automatic test_back_to_back();
        dos = 1'b0; rom48 = 1'b1; romnram = 1'b1;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3DAA, 4, 5);
        checks++; if (n_on !== 1) begin errors++; $display("FAIL b2b_first: got %0d want 1", n_on); end
        rom48 = 1'b0;
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3DAA, 4, 5);
        checks++; if (n_on !== 0) begin errors++; $display("FAIL b2b_rom128: got %0d want 0", n_on); end
    endtask

    initial begin
        test_reset();
        test_dos_on();
        test_dos_off();
        test_vg();
        test_nmi();
        test_rst_mid();
        test_inta();
        test_glitch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
